word_uart_tx: RTL and testbench



---
 rtl/word_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_word_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_uart_tx.sv
// Serialises a 32-bit word onto an RS232 TX line, LSB byte first, 8N1/8N2 frames.
// Define WORD_UART_TX_PARITY_EN to append an even-parity bit after each byte's data bits.
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        drop
);

`ifdef WORD_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [15:0] RELOAD    = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(NUM_BYTES - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;

  logic        start_edge;
  logic        bit_end;
  logic [4:0]  byte_base;
  logic [7:0]  cur_byte;

  always_comb begin
    s1_d       = start;
    s2_d       = s1_q;
    s3_d       = s2_q;
    start_edge = s2_q & ~s3_q;
    bit_end    = (cnt_q == 16'd0);
    byte_base  = {byte_idx_q, 3'b000};
    cur_byte   = shadow_q[byte_base +: 8];

    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d = RELOAD;
      if (start_edge) begin
        shadow_d   = data_in;
        byte_idx_d = 2'd0;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        state_d    = S_START;
      end
    end else begin
      // Any request arriving mid-word is discarded; the word in flight is untouched.
      drop_d = start_edge;
      cnt_d  = bit_end ? RELOAD : cnt_q - 16'd1;
      if (bit_end) begin
        case (state_q)
          S_START: begin
            bit_idx_d = 3'd0;
            tx_d      = cur_byte[0];
            state_d   = S_DATA;
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
`ifdef WORD_UART_TX_PARITY_EN
              tx_d    = ^cur_byte;
              state_d = S_PARITY;
`else
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = S_STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = cur_byte[bit_idx_q + 3'd1];
            end
          end
`ifdef WORD_UART_TX_PARITY_EN
          S_PARITY: begin
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = S_STOP;
          end
`endif
          S_STOP: begin
            if (stop_idx_q != LAST_STOP) begin
              stop_idx_d = stop_idx_q + 1'b1;
            end else if (byte_idx_q != LAST_BYTE) begin
              // Back-to-back frames: next start bit follows the stop bit directly.
              byte_idx_d = byte_idx_q + 2'd1;
              tx_d       = 1'b0;
              state_d    = S_START;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      byte_idx_q <= 2'd0;
      shadow_q   <= 32'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: two configurations, line decoded against a bit-list model of each word.
module tb_word_uart_tx;

  localparam int CA = 4;
  localparam int NA = 4;
  localparam int SA = 1;
  localparam int CB = 5;
  localparam int NB = 1;
  localparam int SB = 2;
`ifdef WORD_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FA = 10 + SA - 1 + PAR;
  localparam int FB = 10 + SB - 1 + PAR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        tx_a, busy_a, done_a, drop_a;
  logic        tx_b, busy_b, done_b, drop_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt_a = 0, drop_cnt_a = 0, done_cnt_b = 0, drop_cnt_b = 0;
  int hold_left = 0;
  bit hold_inst = 1'b0;

  word_uart_tx #(.CLKS_PER_BIT(CA), .NUM_BYTES(NA), .STOP_BITS(SA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_in(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .drop(drop_a));

  word_uart_tx #(.CLKS_PER_BIT(CB), .NUM_BYTES(NB), .STOP_BITS(SB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_in(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .drop(drop_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (drop_a) drop_cnt_a <= drop_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (drop_b) drop_cnt_b <= drop_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input bit i);
    return i ? tx_b : tx_a;
  endfunction
  function automatic logic busy_of(input bit i);
    return i ? busy_b : busy_a;
  endfunction
  function automatic logic done_of(input bit i);
    return i ? done_b : done_a;
  endfunction

  task automatic set_start(input bit i, input logic v);
    if (i) start_b = v;
    else   start_a = v;
  endtask

  task automatic step();
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) set_start(hold_inst, 1'b0);
    end
  endtask

  // Sends one word and decodes the line by mid-bit sampling against the expected bit list.
  task automatic run_word(input bit inst, input logic [31:0] w, input int hold,
                          input bit inject, input int abort_at);
    int c, n, s, f, nbits, c0, e, tgt, pos;
    bit seen;
    logic exp_bits[$];
    logic [7:0] b8;
    logic [11:0] gotf, expf;
    c = inst ? CB : CA;
    n = inst ? NB : NA;
    s = inst ? SB : SA;
    f = inst ? FB : FA;
    exp_bits = {};
    for (int b = 0; b < n; b++) begin
      b8 = w[8*b +: 8];
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(b8[j]);
      if (PAR == 1) exp_bits.push_back(^b8);
      for (int t = 0; t < s; t++) exp_bits.push_back(1'b1);
    end
    nbits = exp_bits.size();
    gotf = '0;
    expf = '0;

    step();
    if (inst) data_b = w;
    else      data_a = w;
    set_start(inst, 1'b1);
    hold_left = hold;
    hold_inst = inst;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_of(inst) == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tx_fall_latency", seen ? cyc - c0 : -1, 3);
    if (!seen) return;
    e = cyc;

    for (int k = 0; k < nbits; k++) begin
      tgt = e + k * c + c / 2;
      while (cyc < tgt) step();
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_tx", tx_a, 1);
        chk("reset_mid_busy", busy_a, 0);
        set_start(inst, 1'b0);
        hold_left = 0;
        step();
        reset = 1'b0;
        return;
      end
      if (inject && k == f) begin
        set_start(inst, 1'b1);
        if (inst) data_b = 32'hFFFF_FFFF;
        else      data_a = 32'hFFFF_FFFF;
      end
      if (inject && k == f + 3) set_start(inst, 1'b0);
      if (k == 0) chk("busy_during_word", busy_of(inst), 1);
      pos = k % f;
      gotf[pos] = tx_of(inst);
      expf[pos] = exp_bits[k];
      if (pos == f - 1) begin
        chk("frame_bits", {20'd0, gotf}, {20'd0, expf});
        gotf = '0;
        expf = '0;
      end
    end

    while (!done_of(inst) && cyc < e + nbits * c + 8) step();
    chk("word_duration", done_of(inst) ? cyc - e : -1, nbits * c);
    step();
    chk("done_one_cycle", done_of(inst), 0);
    chk("busy_after_done", busy_of(inst), 0);
    chk("tx_idle_after", tx_of(inst), 1);
  endtask

  initial begin
    int d0, p0, db0;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_drop_a", drop_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    repeat (3) step();

    // Known word, short start pulse.
    d0 = done_cnt_a; p0 = drop_cnt_a;
    run_word(1'b0, 32'hA53C_0F81, 2, 1'b0, -1);
    step();
    chk("done_count_basic", done_cnt_a - d0, 1);
    chk("drop_count_basic", drop_cnt_a - p0, 0);

    // Second request at byte 1 must be dropped, word unchanged.
    d0 = done_cnt_a; p0 = drop_cnt_a;
    run_word(1'b0, 32'h1234_5678, 2, 1'b1, -1);
    step();
    chk("done_count_drop", done_cnt_a - d0, 1);
    chk("drop_count_drop", drop_cnt_a - p0, 1);

    // Start held high for 500 cycles: one word only.
    d0 = done_cnt_a; p0 = drop_cnt_a;
    run_word(1'b0, 32'hC0DE_1234, 500, 1'b0, -1);
    while (hold_left > 0) step();
    repeat (20) step();
    chk("done_count_held", done_cnt_a - d0, 1);
    chk("drop_count_held", drop_cnt_a - p0, 0);

`ifdef WORD_UART_TX_PARITY_EN
    run_word(1'b0, 32'h0000_0301, 2, 1'b0, -1);
`endif

    // Reset in byte 2 data bit 3, then a full new word.
    run_word(1'b0, 32'hDEAD_BEEF, 2, 1'b0, 2 * FA + 4);
    repeat (3) step();
    d0 = done_cnt_a;
    run_word(1'b0, $urandom, 2, 1'b0, -1);
    step();
    chk("done_count_after_reset", done_cnt_a - d0, 1);

    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      run_word(1'b0, w, $urandom_range(1, 4), 1'b0, -1);
      repeat ($urandom_range(0, 5)) step();
    end

    // Single-byte, two-stop-bit configuration.
    db0 = done_cnt_b;
    run_word(1'b1, 32'h0000_00C3, 2, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      run_word(1'b1, w, $urandom_range(1, 4), 1'b0, -1);
    end
    step();
    chk("done_count_b", done_cnt_b - db0, 4);
    chk("drop_count_b", drop_cnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
